// File: rtl/trena_pkg.sv
// Shared timing constants and state codes for the trena and the HC-SR04 emulator.
// Both sides take the cm definition from here so their distance scales match.
package trena_pkg;

    localparam int CICLOS_POR_CM  = 2941;
    localparam int MIN_TRIGGER    = 500;
    localparam int ATRASO_ECHO    = 12500;
    localparam int DIST_MAX       = 400;
    localparam int CICLOS_TIMEOUT = 1900000;
    localparam int LARGURA_CONT   = 22;

    typedef enum logic [2:0] {
        REPOUSO      = 3'd0,
        TRIGGER_ALTO = 3'd1,
        ATRASO       = 3'd2,
        ECHO         = 3'd3,
        FIM          = 3'd4
    } estado_t;

    // Shift-and-add conversion; digits above 9 still produce a value, validity is checked apart.
    function automatic logic [10:0] bcd_para_bin(input logic [11:0] bcd);
        logic [10:0] h;
        logic [10:0] t;
        logic [10:0] u;
        h = {7'd0, bcd[11:8]};
        t = {7'd0, bcd[7:4]};
        u = {7'd0, bcd[3:0]};
        return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + u;
    endfunction

endpackage

// File: rtl/sensor_ultrassom_emulador_contador_m.sv
// Generic modulo-M counter: zera clears, conta advances, fim flags the last count (M-1).
module contador_m #(
    parameter int M = 10,
    parameter int N = 22
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q;

    assign fim = (q == N'(M - 1));

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            q <= '0;
        end else if (conta) begin
            q <= fim ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_ultrassom_emulador.sv
// HC-SR04 emulator: accepts a long enough trigger, waits the burst delay, then
// drives echo for distance*CICLOS_POR_CM cycles (or the timeout width if invalid).
module sensor_ultrassom_emulador
    import trena_pkg::*;
#(
    parameter int CICLOS_POR_CM  = trena_pkg::CICLOS_POR_CM,
    parameter int MIN_TRIGGER    = trena_pkg::MIN_TRIGGER,
    parameter int ATRASO_ECHO    = trena_pkg::ATRASO_ECHO,
    parameter int DIST_MAX       = trena_pkg::DIST_MAX,
    parameter int CICLOS_TIMEOUT = trena_pkg::CICLOS_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [11:0] distancia_bcd,
    output logic        echo,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    estado_t     estado;
    logic        trig_m;
    logic        trig_s;
    logic        trig_d;
    logic        larg_fim;
    logic        atraso_fim;
    logic        tick_fim;
    logic        timeout_fim;
    logic [8:0]  cm_cnt;
    logic [8:0]  cm_alvo;
    logic        valido;
    logic [10:0] dist_bin;
    logic        digitos_ok;
    logic        dist_ok;
    logic        fim_echo;

    always_ff @(posedge clock) begin
        if (reset) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
            trig_d <= trig_s;
        end
    end

    // Width counter saturates at MIN_TRIGGER, so its fim means "pulse long enough".
    contador_m #(.M(MIN_TRIGGER + 1), .N(LARGURA_CONT)) u_largura (
        .clock (clock),
        .reset (reset),
        .zera  (estado == REPOUSO),
        .conta ((estado == TRIGGER_ALTO) && trig_s && !larg_fim),
        .fim   (larg_fim)
    );

    contador_m #(.M(ATRASO_ECHO), .N(LARGURA_CONT)) u_atraso (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ATRASO),
        .conta (estado == ATRASO),
        .fim   (atraso_fim)
    );

    contador_m #(.M(CICLOS_POR_CM), .N(LARGURA_CONT)) u_tick_cm (
        .clock (clock),
        .reset (reset),
        .zera  ((estado != ECHO) || !valido),
        .conta (estado == ECHO),
        .fim   (tick_fim)
    );

    contador_m #(.M(CICLOS_TIMEOUT), .N(LARGURA_CONT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  ((estado != ECHO) || valido),
        .conta (estado == ECHO),
        .fim   (timeout_fim)
    );

    assign dist_bin   = bcd_para_bin(distancia_bcd);
    assign digitos_ok = (distancia_bcd[11:8] <= 4'd9) && (distancia_bcd[7:4] <= 4'd9)
                        && (distancia_bcd[3:0] <= 4'd9);
    assign dist_ok    = digitos_ok && (dist_bin != 11'd0) && (dist_bin <= 11'(DIST_MAX));
    assign fim_echo   = valido ? (tick_fim && (cm_cnt == cm_alvo - 9'd1)) : timeout_fim;
    assign db_estado  = {1'b0, estado};

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= REPOUSO;
            echo    <= 1'b0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
            cm_cnt  <= 9'd0;
            cm_alvo <= 9'd0;
            valido  <= 1'b0;
        end else begin
            case (estado)
                REPOUSO: begin
                    if (trig_s && !trig_d) begin
                        estado <= TRIGGER_ALTO;
                    end
                end
                TRIGGER_ALTO: begin
                    if (!trig_s) begin
                        if (larg_fim) begin
                            cm_alvo <= dist_bin[8:0];
                            valido  <= dist_ok;
                            ocupado <= 1'b1;
                            estado  <= ATRASO;
                        end else begin
                            estado <= REPOUSO;
                        end
                    end
                end
                ATRASO: begin
                    if (atraso_fim) begin
                        echo   <= 1'b1;
                        estado <= ECHO;
                    end
                end
                ECHO: begin
                    if (fim_echo) begin
                        echo   <= 1'b0;
                        pronto <= 1'b1;
                        cm_cnt <= 9'd0;
                        estado <= FIM;
                    end else if (tick_fim) begin
                        cm_cnt <= cm_cnt + 9'd1;
                    end
                end
                FIM: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= REPOUSO;
                end
                default: begin
                    echo    <= 1'b0;
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= REPOUSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_ultrassom_emulador.sv
// Scoreboard bench for the HC-SR04 emulator with small timing parameters.
module tb_sensor_ultrassom_emulador;

    localparam int CPC   = 4;
    localparam int MIN_T = 5;
    localparam int ATR   = 3;
    localparam int DMAX  = 400;
    localparam int TOUT  = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        trigger;
    logic [11:0] distancia_bcd;
    logic        echo;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    typedef struct {
        int n;
        int rise;
        bit abort;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    sensor_ultrassom_emulador #(
        .CICLOS_POR_CM  (CPC),
        .MIN_TRIGGER    (MIN_T),
        .ATRASO_ECHO    (ATR),
        .DIST_MAX       (DMAX),
        .CICLOS_TIMEOUT (TOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .trigger       (trigger),
        .distancia_bcd (distancia_bcd),
        .echo          (echo),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nome, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nome, act, exp, cyc);
        end
    endtask

    // Reference: echo length in clock cycles for a BCD distance.
    function automatic int model_n(input logic [11:0] b);
        int h, t, u, d;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        if (h > 9 || t > 9 || u > 9) return TOUT;
        d = 100 * h + 10 * t + u;
        if (d < 1 || d > DMAX) return TOUT;
        return d * CPC;
    endfunction

    // Monitor: measures every echo pulse and compares it to the scoreboard head.
    bit   em_pulso = 0;
    bit   prev_echo = 0;
    bit   chk_pronto_baixo = 0;
    int   larg = 0;
    exp_t cur;

    always @(negedge clock) begin
        if (reset) begin
            prev_echo        = 0;
            em_pulso         = 0;
            chk_pronto_baixo = 0;
        end else begin
            if (echo && !prev_echo) begin
                if (sb.size() == 0) begin
                    check("unexpected_echo", 1, 0);
                    cur.n = 0; cur.rise = 0; cur.abort = 1;
                end else begin
                    cur = sb.pop_front();
                    check("echo_latency", cyc, cur.rise);
                end
                em_pulso = 1;
                larg     = 1;
                check("ocupado_in_echo", int'(ocupado), 1);
            end else if (echo && prev_echo) begin
                larg++;
            end else if (!echo && prev_echo) begin
                if (!cur.abort) check("echo_width", larg, cur.n);
                check("pronto_pulse", int'(pronto), 1);
                em_pulso         = 0;
                chk_pronto_baixo = 1;
            end else if (chk_pronto_baixo) begin
                check("pronto_one_cycle", int'(pronto), 0);
                chk_pronto_baixo = 0;
            end
            prev_echo = echo;
        end
    end

    task automatic esperar_echo(output bit ok);
        int guard;
        guard = ATR + 12;
        while (!echo && guard > 0) begin
            @(posedge clock); #1;
            guard--;
        end
        ok = echo;
        check("echo_wait_timeout", int'(guard == 0), 0);
    endtask

    // modo 0: plain, 1: trigger+distance change during echo, 2: reset mid-echo
    task automatic do_txn(input logic [11:0] bcd, input int w, input int modo);
        exp_t e;
        int   fall_c;
        int   n;
        int   guard;
        bit   aceito;
        bit   viu;
        bit   ok;
        @(posedge clock); #1;
        distancia_bcd = bcd;
        trigger       = 1'b1;
        repeat (w) @(posedge clock);
        #1;
        trigger = 1'b0;
        fall_c  = cyc;
        aceito  = (w > MIN_T);
        n       = model_n(bcd);
        if (aceito) begin
            e.n     = n;
            e.rise  = fall_c + 1 + ATR + 2;
            e.abort = (modo == 2);
            sb.push_back(e);
        end
        repeat (3) @(posedge clock);
        #1;
        distancia_bcd = 12'($urandom);
        if (!aceito) begin
            viu = 0;
            repeat (ATR + 10) begin
                @(posedge clock); #1;
                if (ocupado || echo) viu = 1;
            end
            check("runt_quiet", int'(viu), 0);
            check("runt_state", int'(db_estado), 0);
            return;
        end
        if (modo != 0) begin
            esperar_echo(ok);
            if (ok && modo == 1) begin
                trigger       = 1'b1;
                distancia_bcd = 12'h099;
                repeat (6) @(posedge clock);
                #1;
                trigger = 1'b0;
            end else if (ok && modo == 2) begin
                repeat (5) @(posedge clock);
                #1;
                reset = 1'b1;
                @(posedge clock); #1;
                check("rst_echo", int'(echo), 0);
                check("rst_ocupado", int'(ocupado), 0);
                check("rst_pronto", int'(pronto), 0);
                check("rst_estado", int'(db_estado), 0);
                reset = 1'b0;
            end
        end
        guard = n + ATR + 20;
        while (ocupado && guard > 0) begin
            @(posedge clock); #1;
            guard--;
        end
        check("busy_timeout", int'(guard == 0), 0);
        repeat ($urandom_range(5, 2)) @(posedge clock);
        if (modo == 1) begin
            repeat (20) @(posedge clock);
            #1;
            check("no_second_echo", int'(ocupado), 0);
        end
    endtask

    function automatic logic [11:0] rand_bcd();
        int k;
        k = $urandom_range(9, 0);
        if (k < 7) return {4'($urandom_range(4, 0)), 4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
        if (k == 7) return 12'h000;
        return 12'($urandom);
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset         = 1'b1;
        trigger       = 1'b0;
        distancia_bcd = 12'h000;
        repeat (3) @(posedge clock);
        #1;
        check("reset_echo", int'(echo), 0);
        check("reset_ocupado", int'(ocupado), 0);
        check("reset_pronto", int'(pronto), 0);
        check("reset_estado", int'(db_estado), 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        do_txn(12'h012, 6, 0);
        do_txn(12'h012, 4, 0);
        do_txn(12'h401, 6, 0);
        do_txn(12'h000, 6, 0);
        do_txn(12'h0A5, 8, 0);
        do_txn(12'h400, 6, 0);
        do_txn(12'h001, 9, 0);
        do_txn(12'h010, 6, 1);
        do_txn(12'h050, 7, 2);
        do_txn(12'h023, 6, 0);

        for (int i = 0; i < 20; i++) begin
            w = $urandom_range(10, 1);
            if (w == MIN_T) w = MIN_T + 1;
            do_txn(rand_bcd(), w, 0);
        end

        repeat (10) @(posedge clock);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
